spi_master_cfg: RTL and testbench
=================================

SPI_MASTER_CFG -- requirements
Module: spi_master_cfg

Interface
REQ-001 Parameters: DATA_WIDTH, default 16, maximum bits per transfer; NUM_CS, default 4, chip-select lines; DIV_W, default 8, width of the clock-divider field.
REQ-002 clk  in  1  system clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 cmd_vld  in  1  command valid.
REQ-005 cmd_rdy  out  1  block can accept a command.
REQ-006 cmd_data  in  DATA_WIDTH  transmit word, right-aligned, sent MSB of the active length first.
REQ-007 cmd_len  in  $clog2(DATA_WIDTH)  bits-per-transfer minus 1.
REQ-008 cmd_cs  in  $clog2(NUM_CS) (min 1)  chip-select index.
REQ-009 cmd_cpol, cmd_cpha  in  1 each  SPI mode bits.
REQ-010 cmd_div  in  DIV_W  SCLK half-period in clk cycles.
REQ-011 rsp_vld  out  1  one-cycle pulse, receive word valid.
REQ-012 rsp_data  out  DATA_WIDTH  received word, right-aligned, upper bits zero.
REQ-013 sclk  out  1  serial clock.
REQ-014 cs_n  out  NUM_CS  active-low chip selects, one-hot-low or all high.
REQ-015 mosi  out  1  serial data out.
REQ-016 miso  in  1  serial data in, already synchronous to clk.
REQ-017 busy  out  1  high whenever the state is not IDLE.

Function
REQ-018 FSM states: IDLE, SETUP, XFER, HOLD; IDLE->SETUP on cmd fire; SETUP->XFER after H cycles; XFER->HOLD after 2N SCLK edges; HOLD->IDLE after H cycles.
REQ-019 cmd_rdy = (state == IDLE); fire = cmd_vld && cmd_rdy; all cmd_* fields are latched on fire and ignored otherwise.
REQ-020 H = cmd_div, with cmd_div = 0 treated as 1; N = cmd_len + 1, clamped to DATA_WIDTH if larger.
REQ-021 Fire at cycle T gives cs_n[cmd_cs] low at T+1, the first SCLK edge at T+1+H, consecutive edges every H cycles, and cs_n high at T+1+(2N+2)*H.
REQ-022 sclk idles at the latched CPOL from fire+1 through the end of HOLD; it is a register, glitch-free.
REQ-023 CPHA=0: mosi presents bit N-1 from cs_n assertion; miso is sampled on each leading edge; mosi shifts on each trailing edge.
REQ-024 CPHA=1: mosi shifts on each leading edge, starting with bit N-1; miso is sampled on each trailing edge.
REQ-025 miso is sampled on the same clk edge at which the sclk register toggles to the sampling edge.
REQ-026 rsp_vld pulses for exactly one cycle on the cycle cs_n deasserts; rsp_data holds its value until the next rsp_vld.
REQ-027 cmd_rdy returns high on the same cycle as rsp_vld; a back-to-back command guarantees cs_n is high for at least 1 cycle between transfers.
REQ-028 cmd_cs >= NUM_CS: all cs_n stay high; the transfer still runs with full timing and rsp_vld.
REQ-029 cmd_vld asserted while busy is ignored with no side effects.
REQ-030 mosi = 0 while in IDLE.

Reset
REQ-031 Reset values: sclk=0, cs_n=all 1, mosi=0, rsp_vld=0, rsp_data=0, busy=0, cmd_rdy=1 from the first cycle after release.
REQ-032 Reset mid-transfer aborts immediately, with no rsp_vld and no partial rsp_data update.

Structure
REQ-033 Package spi_pkg holds the state encoding, the CPOL/CPHA mode constants, and the default DATA_WIDTH/NUM_CS/DIV_W values.
REQ-034 Sub-module spi_clk_gen (half-period counter producing lead/trail edge strobes and the sclk register) is instantiated once; shift registers and FSM live in spi_master_cfg.

Verification
REQ-035 Mode 0, DATA_WIDTH=8, div=2, len=7, data=0xA5, miso looped to mosi -> rsp_data=0xA5; cs_n low for 36 cycles; 16 sclk edges.
REQ-036 Modes 1, 2 and 3, same stimulus, miso driven by a mode-correct slave model returning 0x3C -> rsp_data=0x3C; sclk idle level equals CPOL.
REQ-037 len=3, data=0x0D, div=0 -> 4 bits 1,1,0,1 on mosi; H=1; rsp_data upper 12 bits zero.
REQ-038 Two commands with cmd_vld held high, cs=1 then cs=3 -> second fire on the rsp_vld cycle; 1 cycle of all-high cs_n between transfers; second command ignored while busy.
REQ-039 cmd_cs=NUM_CS -> cs_n stays all high, rsp_vld still pulses at T+1+(2N+2)*H.
REQ-040 rst_n low mid-XFER -> outputs return to reset values asynchronously; no rsp_vld; cmd_rdy=1 after release; next transfer correct.

Source files
------------

// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg: FSM encoding, SPI mode constants and defaults for spi_master_cfg.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_XFER  = 2'd2,
      ST_HOLD  = 2'd3
   } state_e;

   localparam logic CPOL_IDLE_LOW  = 1'b0;
   localparam logic CPOL_IDLE_HIGH = 1'b1;
   localparam logic CPHA_LEAD      = 1'b0;
   localparam logic CPHA_TRAIL     = 1'b1;

   // {cpol, cpha}
   localparam logic [1:0] SPI_MODE0 = 2'b00;
   localparam logic [1:0] SPI_MODE1 = 2'b01;
   localparam logic [1:0] SPI_MODE2 = 2'b10;
   localparam logic [1:0] SPI_MODE3 = 2'b11;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_NUM_CS     = 4;
   localparam int DEF_DIV_W      = 8;

   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/spi_master_cfg_if.sv
// ---------------------------------------------------------------------------
// spi_master_cfg_if: command/response handshake bundle of spi_master_cfg.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface spi_master_cfg_if
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_CS     = DEF_NUM_CS,
   parameter int DIV_W      = DEF_DIV_W
) ();

   localparam int LEN_W = clog2_min1(DATA_WIDTH);
   localparam int CS_W  = clog2_min1(NUM_CS);

   logic                  cmd_vld;
   logic                  cmd_rdy;
   logic [DATA_WIDTH-1:0] cmd_data;
   logic [LEN_W-1:0]      cmd_len;
   logic [CS_W-1:0]       cmd_cs;
   logic                  cmd_cpol;
   logic                  cmd_cpha;
   logic [DIV_W-1:0]      cmd_div;
   logic                  rsp_vld;
   logic [DATA_WIDTH-1:0] rsp_data;

   modport master (
      output cmd_vld, cmd_data, cmd_len, cmd_cs, cmd_cpol, cmd_cpha, cmd_div,
      input  cmd_rdy, rsp_vld, rsp_data
   );

   modport slave (
      input  cmd_vld, cmd_data, cmd_len, cmd_cs, cmd_cpol, cmd_cpha, cmd_div,
      output cmd_rdy, rsp_vld, rsp_data
   );

endinterface

`default_nettype wire

// File: rtl/spi_clk_gen.sv
// ---------------------------------------------------------------------------
// spi_clk_gen: half-period counter, lead/trail edge strobes, registered sclk.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_clk_gen
   import spi_pkg::*;
#(
   parameter int DIV_W = DEF_DIV_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [DIV_W-1:0] half,
   input  logic             edge_en,
   input  logic             load,
   input  logic             load_val,
   input  logic             idle,
   output logic             tick,
   output logic             lead,
   output logic             trail,
   output logic             sclk
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             sclk_q, sclk_d;
   logic             toggle;

   always_comb begin
      tick   = run && (cnt_q == (half - DIV_W'(1)));
      toggle = tick && edge_en;
      lead   = toggle && (sclk_q == idle);
      trail  = toggle && (sclk_q != idle);
      cnt_d  = cnt_q + DIV_W'(1);
      if (!run || tick) begin
         cnt_d = '0;
      end
      // load wins so sclk sits at the new idle level from the cycle after fire
      sclk_d = sclk_q;
      if (load) begin
         sclk_d = load_val;
      end else if (toggle) begin
         sclk_d = ~sclk_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

   assign sclk = sclk_q;

endmodule

`default_nettype wire

// File: rtl/spi_master_cfg.sv
// ---------------------------------------------------------------------------
// spi_master_cfg: per-command configurable SPI master (mode, length, CS, rate).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_master_cfg
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_CS     = DEF_NUM_CS,
   parameter int DIV_W      = DEF_DIV_W
) (
   input  logic              clk,
   input  logic              rst_n,
   spi_master_cfg_if.slave   bus,
   output logic              sclk,
   output logic [NUM_CS-1:0] cs_n,
   output logic              mosi,
   input  logic              miso,
   output logic              busy
);

   localparam int N_W = $clog2(DATA_WIDTH + 1);

   state_e                state_q, state_d;
   logic                  cpol_q, cpol_d;
   logic                  cpha_q, cpha_d;
   logic [N_W-1:0]        n_q, n_d;
   logic [DIV_W-1:0]      half_q, half_d;
   logic [N_W:0]          edges_q, edges_d;
   logic [DATA_WIDTH-1:0] tx_q, tx_d;
   logic [DATA_WIDTH-1:0] rx_q, rx_d;
   logic [NUM_CS-1:0]     cs_n_q, cs_n_d;
   logic                  mosi_q, mosi_d;
   logic                  rsp_vld_q, rsp_vld_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

   logic                  fire;
   logic                  run;
   logic                  tick;
   logic                  lead;
   logic                  trail;
   logic                  edge_en;
   logic                  sample;
   logic                  shift;
   logic [N_W:0]          two_n;
   int                    n_int;
   logic [N_W-1:0]        n_cmd;
   logic [DATA_WIDTH-1:0] aligned;
   logic [NUM_CS-1:0]     cs_dec;

   assign fire    = bus.cmd_vld && (state_q == ST_IDLE);
   assign run     = (state_q != ST_IDLE);
   assign two_n   = {n_q, 1'b0};
   assign edge_en = (state_q == ST_SETUP) ||
                    ((state_q == ST_XFER) && (edges_q != two_n));
   assign sample  = (cpha_q == CPHA_LEAD) ? lead  : trail;
   assign shift   = (cpha_q == CPHA_LEAD) ? trail : lead;

   // Left-align the active bits so the shifter always emits from the MSB.
   always_comb begin
      n_int = int'(bus.cmd_len) + 1;
      if (n_int > DATA_WIDTH) begin
         n_int = DATA_WIDTH;
      end
      n_cmd   = N_W'(n_int);
      aligned = bus.cmd_data << (DATA_WIDTH - n_int);
      cs_dec  = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if (int'(bus.cmd_cs) == i) begin
            cs_dec[i] = 1'b0;
         end
      end
   end

   spi_clk_gen #(
      .DIV_W (DIV_W)
   ) u_clk_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (run),
      .half     (half_q),
      .edge_en  (edge_en),
      .load     (fire),
      .load_val (bus.cmd_cpol),
      .idle     (cpol_q),
      .tick     (tick),
      .lead     (lead),
      .trail    (trail),
      .sclk     (sclk)
   );

   always_comb begin
      state_d    = state_q;
      cpol_d     = cpol_q;
      cpha_d     = cpha_q;
      n_d        = n_q;
      half_d     = half_q;
      edges_d    = edges_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      cs_n_d     = cs_n_q;
      mosi_d     = mosi_q;
      rsp_vld_d  = 1'b0;
      rsp_data_d = rsp_data_q;

      if (sample) begin
         rx_d    = rx_q << 1;
         rx_d[0] = miso;
      end
      if (shift) begin
         mosi_d = tx_q[DATA_WIDTH-1];
         tx_d   = tx_q << 1;
      end

      case (state_q)
         ST_IDLE: begin
            if (fire) begin
               state_d = ST_SETUP;
               cpol_d  = bus.cmd_cpol;
               cpha_d  = bus.cmd_cpha;
               n_d     = n_cmd;
               half_d  = (bus.cmd_div == '0) ? DIV_W'(1) : bus.cmd_div;
               edges_d = '0;
               rx_d    = '0;
               cs_n_d  = cs_dec;
               // CPHA=0 must present the first bit before the first edge
               if (bus.cmd_cpha == CPHA_LEAD) begin
                  mosi_d = aligned[DATA_WIDTH-1];
                  tx_d   = aligned << 1;
               end else begin
                  mosi_d = 1'b0;
                  tx_d   = aligned;
               end
            end
         end
         ST_SETUP: begin
            if (tick) begin
               state_d = ST_XFER;
               edges_d = edges_q + 1'b1;
            end
         end
         ST_XFER: begin
            if (tick) begin
               if (edges_q == two_n) begin
                  state_d = ST_HOLD;
               end else begin
                  edges_d = edges_q + 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (tick) begin
               state_d    = ST_IDLE;
               cs_n_d     = '1;
               mosi_d     = 1'b0;
               rsp_vld_d  = 1'b1;
               rsp_data_d = rx_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         n_q        <= '0;
         half_q     <= DIV_W'(1);
         edges_q    <= '0;
         tx_q       <= '0;
         rx_q       <= '0;
         cs_n_q     <= '1;
         mosi_q     <= 1'b0;
         rsp_vld_q  <= 1'b0;
         rsp_data_q <= '0;
      end else begin
         state_q    <= state_d;
         cpol_q     <= cpol_d;
         cpha_q     <= cpha_d;
         n_q        <= n_d;
         half_q     <= half_d;
         edges_q    <= edges_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         cs_n_q     <= cs_n_d;
         mosi_q     <= mosi_d;
         rsp_vld_q  <= rsp_vld_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   assign bus.cmd_rdy  = (state_q == ST_IDLE);
   assign bus.rsp_vld  = rsp_vld_q;
   assign bus.rsp_data = rsp_data_q;
   assign cs_n         = cs_n_q;
   assign mosi         = mosi_q;
   assign busy         = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_spi_master_cfg.sv
// ---------------------------------------------------------------------------
// tb_spi_master_cfg: directed + random transfers against a timing/data model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spi_master_cfg;
   import spi_pkg::*;

   localparam int DW    = 16;
   localparam int NCS   = 5;
   localparam int DIVW  = 8;
   localparam int LEN_W = 4;
   localparam int CS_W  = 3;
   localparam logic [NCS-1:0] CS_IDLE = '1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_master_cfg_if #(.DATA_WIDTH(DW), .NUM_CS(NCS), .DIV_W(DIVW)) bus ();

   logic           sclk, mosi, miso, busy;
   logic [NCS-1:0] cs_n;

   spi_master_cfg #(.DATA_WIDTH(DW), .NUM_CS(NCS), .DIV_W(DIVW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .sclk  (sclk),
      .cs_n  (cs_n),
      .mosi  (mosi),
      .miso  (miso),
      .busy  (busy)
   );

   int n_pass  = 0;
   int n_total = 0;

   // Slave model: shifts a word out MSB-first on its mode's shift edge.
   bit          loop_mode = 1'b1;
   logic [15:0] sl_word   = '0;
   int          sl_n      = 1;
   bit          sl_cpol   = 1'b0;
   bit          sl_cpha   = 1'b0;
   logic        miso_s    = 1'b0;
   int          sl_idx    = 0;
   logic        sl_prev_sclk = 1'b0;
   logic        sl_prev_act  = 1'b0;

   assign miso = loop_mode ? mosi : miso_s;

   always @(negedge clk) begin
      sl_prev_sclk <= sclk;
      sl_prev_act  <= (cs_n != CS_IDLE);
      if (cs_n == CS_IDLE) begin
         miso_s <= 1'b0;
      end else if (!sl_prev_act) begin
         if (!sl_cpha) begin
            miso_s <= sl_word[sl_n-1];
            sl_idx <= sl_n - 1;
         end else begin
            miso_s <= 1'b0;
            sl_idx <= sl_n;
         end
      end else if ((sclk != sl_prev_sclk) &&
                   (sl_cpha ? (sclk != sl_cpol) : (sclk == sl_cpol))) begin
         sl_idx <= sl_idx - 1;
         miso_s <= (sl_idx >= 1) ? sl_word[sl_idx-1] : 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic drive_cmd(input logic [15:0] d, input int len, input int cs,
                            input bit cpol, input bit cpha, input int div);
      bus.cmd_data = d;
      bus.cmd_len  = LEN_W'(len);
      bus.cmd_cs   = CS_W'(cs);
      bus.cmd_cpol = cpol;
      bus.cmd_cpha = cpha;
      bus.cmd_div  = DIVW'(div);
   endtask

   task automatic scramble_cmd();
      drive_cmd(16'($urandom), $urandom_range(0, 15), $urandom_range(0, 7),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 255));
   endtask

   // Called at the negedge of fire+1; returns at the negedge where rsp_vld is seen.
   task automatic monitor(input logic [15:0] d, input int len, input int cs,
                          input bit cpol, input bit cpha, input int div,
                          input bit lp, input logic [15:0] word,
                          output logic [15:0] exp_rx);
      int             n      = (len + 1 > DW) ? DW : len + 1;
      int             h      = (div == 0) ? 1 : div;
      int             end_k  = 1 + (2 * n + 2) * h;
      logic [15:0]    mask   = 16'((32'h1 << n) - 1);
      logic [NCS-1:0] exp_cs = (cs < NCS) ? ~(NCS'(1) << cs) : CS_IDLE;
      int             k = 1, edges = 0, bad_edge = 0, cs_low = 0, cs_bad = 0;
      logic           prev;
      logic [15:0]    mo = '0;
      bit             done = 1'b0;

      exp_rx = lp ? (d & mask) : ((cs < NCS) ? (word & mask) : 16'h0);
      check("sclk_idle_at_start", sclk, cpol);
      check("busy_during_xfer", busy, 1);
      check("cmd_rdy_during_xfer", bus.cmd_rdy, 0);
      check("cs_n_assert", cs_n, exp_cs);
      prev = sclk;
      while (!done) begin
         if (k > 1 && sclk !== prev) begin
            edges++;
            if ((k - 1) % h != 0) bad_edge++;
            if ((sclk != cpol) == !cpha) mo = {mo[14:0], mosi};
         end
         prev = sclk;
         if (bus.rsp_vld === 1'b1) begin
            done = 1'b1;
            if (cs_n !== CS_IDLE) cs_bad++;
         end else begin
            if (cs_n != CS_IDLE) cs_low++;
            if (cs_n !== exp_cs) cs_bad++;
            if (k >= end_k + 20) begin
               done = 1'b1;
            end else begin
               @(negedge clk);
               k++;
            end
         end
      end
      check("rsp_vld_cycle", k, end_k);
      check("sclk_edge_count", edges, 2 * n);
      check("sclk_edge_spacing_errs", bad_edge, 0);
      check("cs_n_low_cycles", cs_low, (cs < NCS) ? (2 * n + 2) * h : 0);
      check("cs_n_pattern_errs", cs_bad, 0);
      check("rsp_data", bus.rsp_data, exp_rx);
      check("mosi_word", mo, d & mask);
      check("sclk_idle_at_end", sclk, cpol);
      check("mosi_zero_in_idle", mosi, 0);
      check("cmd_rdy_with_rsp", bus.cmd_rdy, 1);
   endtask

   task automatic run_xfer(input logic [15:0] d, input int len, input int cs,
                           input bit cpol, input bit cpha, input int div,
                           input bit lp, input logic [15:0] word);
      logic [15:0] exp_rx;
      loop_mode = lp;
      sl_word   = word;
      sl_n      = (len + 1 > DW) ? DW : len + 1;
      sl_cpol   = cpol;
      sl_cpha   = cpha;
      @(negedge clk);
      drive_cmd(d, len, cs, cpol, cpha, div);
      bus.cmd_vld = 1'b1;
      check("cmd_rdy_idle", bus.cmd_rdy, 1);
      @(posedge clk);
      @(negedge clk);
      bus.cmd_vld = 1'b0;
      scramble_cmd();
      monitor(d, len, cs, cpol, cpha, div, lp, word, exp_rx);
      @(negedge clk);
      check("rsp_vld_one_cycle", bus.rsp_vld, 0);
      check("rsp_data_held", bus.rsp_data, exp_rx);
   endtask

   initial begin
      logic [15:0] exp_rx;
      bus.cmd_vld = 1'b0;
      drive_cmd('0, 0, 0, 1'b0, 1'b0, 0);

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_sclk", sclk, 0);
      check("rst_cs_n", cs_n, CS_IDLE);
      check("rst_mosi", mosi, 0);
      check("rst_rsp_vld", bus.rsp_vld, 0);
      check("rst_rsp_data", bus.rsp_data, 0);
      check("rst_busy", busy, 0);
      check("rst_cmd_rdy", bus.cmd_rdy, 1);

      // Mode 0 loopback, then modes 1..3 against the slave model
      run_xfer(16'h00A5, 7, 0, 1'b0, 1'b0, 2, 1'b1, 16'h0000);
      for (int m = 1; m < 4; m++) begin
         run_xfer(16'h00A5, 7, m, 1'(m >> 1), 1'(m & 1), 2, 1'b0, 16'h003C);
      end

      // Short word at the fastest rate
      run_xfer(16'h000D, 3, 2, 1'b0, 1'b0, 0, 1'b1, 16'h0000);

      // Out-of-range chip select
      run_xfer(16'h00C3, 7, NCS, 1'b0, 1'b0, 2, 1'b0, 16'h003C);

      // Back-to-back commands with cmd_vld held high
      loop_mode = 1'b1;
      @(negedge clk);
      drive_cmd(16'h005A, 7, 1, 1'b0, 1'b0, 2);
      bus.cmd_vld = 1'b1;
      @(posedge clk);
      @(negedge clk);
      drive_cmd(16'h002B, 5, 3, 1'b1, 1'b1, 1);
      monitor(16'h005A, 7, 1, 1'b0, 1'b0, 2, 1'b1, 16'h0000, exp_rx);
      check("b2b_gap_cs_n", cs_n, CS_IDLE);
      @(posedge clk);
      @(negedge clk);
      bus.cmd_vld = 1'b0;
      monitor(16'h002B, 5, 3, 1'b1, 1'b1, 1, 1'b1, 16'h0000, exp_rx);

      // Asynchronous reset in the middle of a transfer
      @(negedge clk);
      drive_cmd(16'hBEEF, 15, 2, 1'b1, 1'b0, 3);
      bus.cmd_vld = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.cmd_vld = 1'b0;
      repeat (12) @(negedge clk);
      check("pre_reset_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_sclk", sclk, 0);
      check("abort_cs_n", cs_n, CS_IDLE);
      check("abort_mosi", mosi, 0);
      check("abort_rsp_vld", bus.rsp_vld, 0);
      check("abort_rsp_data", bus.rsp_data, 0);
      check("abort_busy", busy, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_cmd_rdy", bus.cmd_rdy, 1);
      check("post_reset_rsp_vld", bus.rsp_vld, 0);
      run_xfer(16'h1234, 11, 4, 1'b0, 1'b1, 1, 1'b1, 16'h0000);

      // Randomised transfers
      for (int t = 0; t < 16; t++) begin
         run_xfer(16'($urandom), $urandom_range(0, 15), $urandom_range(0, 7),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)), 16'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
